// File: rtl/meta_arb_client_if.sv
// Metadata stream bundle between the parser channels, the merging client and the downstream consumer.
// slave: the arbiter side; master: the side driving the channel inputs and consuming the output.
interface meta_arb_client_if #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = $clog2(NUM_CH)
);
    logic [NUM_CH*DATA_WIDTH-1:0] in_meta_data;
    logic [NUM_CH-1:0]            in_meta_valid;
    logic [NUM_CH-1:0]            in_meta_ready;
    logic [DATA_WIDTH-1:0]        out_meta_data;
    logic [CH_W-1:0]              out_meta_ch;
    logic                         out_meta_valid;
    logic                         out_meta_ready;

    modport slave (
        input  in_meta_data, in_meta_valid, out_meta_ready,
        output in_meta_ready, out_meta_data, out_meta_ch, out_meta_valid
    );

    modport master (
        output in_meta_data, in_meta_valid, out_meta_ready,
        input  in_meta_ready, out_meta_data, out_meta_ch, out_meta_valid
    );
endinterface

// File: rtl/meta_arb_client.sv
// Round-robin merge of NUM_CH metadata streams into a 2-entry output buffer, with per-channel flit counters.
// Optional build macro META_ARB_STATS_SAT_EN: counters saturate instead of wrapping.
module meta_arb_client #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    meta_arb_client_if.slave     mif,
    input  logic [CH_W-1:0]      stats_sel,
    input  logic                 stats_clear,
    output logic [CNT_WIDTH-1:0] stats_out
);
    localparam logic [CH_W-1:0]      LAST_INIT  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]        NUM_CH_EXT = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
`ifdef META_ARB_STATS_SAT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
`endif

    logic [DATA_WIDTH-1:0] r_mem_data [2];
    logic [CH_W-1:0]       r_mem_ch   [2];
    logic                  r_head;
    logic [1:0]            r_count;
    logic [CH_W-1:0]       r_last;
    logic [CNT_WIDTH-1:0]  r_cnt      [NUM_CH];
    logic [CNT_WIDTH-1:0]  r_stats_out;

    logic                  w_hi_found;
    logic [CH_W-1:0]       w_hi_idx;
    logic [CH_W-1:0]       w_lo_idx;
    logic [CH_W-1:0]       w_winner;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic                  w_space;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_wr_idx;
    logic                  w_sel_ok;

    // Arbiter: lowest valid channel above last wins, otherwise lowest valid channel at or below it.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = {CH_W{1'b0}};
        w_lo_idx   = {CH_W{1'b0}};
        w_win_data = {DATA_WIDTH{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_hi_found = w_hi_found | (mif.in_meta_valid[i] & (CH_W'(i) > r_last));
            w_hi_idx   = (mif.in_meta_valid[i] && (CH_W'(i) > r_last)) ? CH_W'(i) : w_hi_idx;
            w_lo_idx   = (mif.in_meta_valid[i] && (CH_W'(i) <= r_last)) ? CH_W'(i) : w_lo_idx;
        end
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
        for (int i = 0; i < NUM_CH; i++) begin
            w_win_data = (w_winner == CH_W'(i)) ? mif.in_meta_data[i*DATA_WIDTH +: DATA_WIDTH] : w_win_data;
        end
        // space ignores out_meta_ready so there is no ready-to-ready path
        w_space  = ~r_count[1];
        w_accept = (|mif.in_meta_valid) & w_space & ~rst;
        w_pop    = (r_count != 2'd0) & mif.out_meta_ready;
        w_wr_idx = r_head ^ r_count[0];
        w_sel_ok = ({1'b0, stats_sel} < NUM_CH_EXT);
        mif.in_meta_ready = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            mif.in_meta_ready[i] = w_accept & (w_winner == CH_W'(i));
        end
    end

    assign mif.out_meta_valid = (r_count != 2'd0);
    assign mif.out_meta_data  = r_mem_data[r_head];
    assign mif.out_meta_ch    = r_mem_ch[r_head];
    assign stats_out          = r_stats_out;

    // Output buffer and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < 2; e++) begin
                r_mem_data[e] <= {DATA_WIDTH{1'b0}};
                r_mem_ch[e]   <= {CH_W{1'b0}};
            end
            r_head  <= 1'b0;
            r_count <= 2'd0;
            r_last  <= LAST_INIT;
        end else begin
            if (w_accept) begin
                r_mem_data[w_wr_idx] <= w_win_data;
                r_mem_ch[w_wr_idx]   <= w_winner;
                r_last               <= w_winner;
            end else begin
                r_last <= r_last;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end else begin
                r_head <= r_head;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-channel accept counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (stats_clear) begin
                    r_cnt[i] <= CNT_ZERO;
                end else if (w_accept && (w_winner == CH_W'(i))) begin
`ifdef META_ARB_STATS_SAT_EN
                    r_cnt[i] <= (r_cnt[i] == CNT_MAX) ? CNT_MAX : (r_cnt[i] + CNT_ONE);
`else
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
`endif
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    // Registered stats readback; out-of-range selects read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stats_out <= CNT_ZERO;
        end else if (w_sel_ok) begin
            r_stats_out <= r_cnt[stats_sel];
        end else begin
            r_stats_out <= CNT_ZERO;
        end
    end
endmodule

// File: tb/tb_meta_arb_client.sv
// Directed self-checking bench for meta_arb_client (4 channels, 16-bit flits, 4-bit counters).
module tb_meta_arb_client;
    localparam int DW = 16;
    localparam int NC = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    stats_sel;
    logic          stats_clear;
    logic [CW-1:0] stats_out;
    int            n_checks = 0;
    int            n_errors = 0;

    meta_arb_client_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

    meta_arb_client #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mif         (bus),
        .stats_sel   (stats_sel),
        .stats_clear (stats_clear),
        .stats_out   (stats_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_data(input int ch, input logic [DW-1:0] val);
        bus.in_meta_data[ch*DW +: DW] = val;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_meta_valid  = 4'b0000;
        bus.out_meta_ready = 1'b0;
        stats_clear        = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        stats_sel          = 2'd0;
        stats_clear        = 1'b0;
        bus.in_meta_data   = 64'h0;
        bus.in_meta_valid  = 4'b0001;
        bus.out_meta_ready = 1'b0;

        // reset state, with a channel valid to show ready stays low
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdy",   bus.in_meta_ready, 4'b0000);
        chk("rst_vld",   bus.out_meta_valid, 1'b0);
        chk("rst_data",  bus.out_meta_data, 16'h0);
        chk("rst_ch",    bus.out_meta_ch, 2'd0);
        chk("rst_stats", stats_out, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_meta_valid = 4'b0000;

        // single flit on ch2
        set_data(2, 16'hA5);
        bus.in_meta_valid  = 4'b0100;
        bus.out_meta_ready = 1'b1;
        #1 chk("t1_rdy", bus.in_meta_ready, 4'b0100);
        @(negedge clk);
        bus.in_meta_valid = 4'b0000;
        stats_sel = 2'd2;
        chk("t1_vld",  bus.out_meta_valid, 1'b1);
        chk("t1_data", bus.out_meta_data, 16'hA5);
        chk("t1_ch",   bus.out_meta_ch, 2'd2);
        @(negedge clk);
        chk("t1_stats", stats_out, 4'd1);
        chk("t1_empty", bus.out_meta_valid, 1'b0);

        // fairness: all channels valid for 12 cycles
        do_reset();
        for (int i = 0; i < NC; i++) set_data(i, 16'h10 + 16'(i));
        bus.in_meta_valid  = 4'b1111;
        bus.out_meta_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1 chk("rr_rdy", bus.in_meta_ready, 64'd1 << (k % 4));
            @(negedge clk);
            chk("rr_ch",   bus.out_meta_ch, 64'(k % 4));
            chk("rr_data", bus.out_meta_data, 64'h10 + 64'(k % 4));
        end
        bus.in_meta_valid = 4'b0000;
        for (int i = 0; i < NC; i++) begin
            stats_sel = 2'(i);
            @(negedge clk);
            chk("rr_cnt", stats_out, 4'd3);
        end

        // back-pressure: only two flits buffered, then drain in order
        do_reset();
        bus.in_meta_valid  = 4'b0001;
        bus.out_meta_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            set_data(0, 16'hC0 + 16'((c < 2) ? c : 2));
            #1 chk("stall_rdy", bus.in_meta_ready, (c < 2) ? 4'b0001 : 4'b0000);
            @(negedge clk);
        end
        chk("stall_vld",  bus.out_meta_valid, 1'b1);
        chk("stall_head", bus.out_meta_data, 16'hC0);
        bus.out_meta_ready = 1'b1;
        #1 chk("stall_rdy_full", bus.in_meta_ready, 4'b0000);
        @(negedge clk);
        chk("drain_1",  bus.out_meta_data, 16'hC1);
        chk("drain_rdy", bus.in_meta_ready, 4'b0001);
        @(negedge clk);
        bus.in_meta_valid = 4'b0000;
        chk("drain_2", bus.out_meta_data, 16'hC2);
        chk("drain_2v", bus.out_meta_valid, 1'b1);
        @(negedge clk);
        chk("drain_empty", bus.out_meta_valid, 1'b0);

        // clear collides with a ch1 accept
        do_reset();
        set_data(1, 16'h11);
        bus.in_meta_valid  = 4'b0010;
        bus.out_meta_ready = 1'b1;
        stats_sel          = 2'd1;
        #1 chk("clr_rdy", bus.in_meta_ready, 4'b0010);
        @(negedge clk);
        stats_clear = 1'b1;
        @(negedge clk);
        chk("clr_pre", stats_out, 4'd1);
        bus.in_meta_valid = 4'b0000;
        stats_clear = 1'b0;
        @(negedge clk);
        chk("clr_post", stats_out, 4'd0);

        // counter limit: 17 accepts on ch0 with 4-bit counters
        do_reset();
        set_data(0, 16'h55);
        bus.in_meta_valid  = 4'b0001;
        bus.out_meta_ready = 1'b1;
        stats_sel          = 2'd0;
        repeat (17) @(negedge clk);
        bus.in_meta_valid = 4'b0000;
        @(negedge clk);
`ifdef META_ARB_STATS_SAT_EN
        chk("lim_cnt", stats_out, 4'd15);
`else
        chk("lim_cnt", stats_out, 4'd1);
`endif

        // async reset with a full buffer
        do_reset();
        set_data(1, 16'h77);
        bus.in_meta_valid  = 4'b0010;
        bus.out_meta_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_vld_pre", bus.out_meta_valid, 1'b1);
        chk("ar_ch_pre",  bus.out_meta_ch, 2'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_vld",  bus.out_meta_valid, 1'b0);
        chk("ar_data", bus.out_meta_data, 16'h0);
        chk("ar_ch",   bus.out_meta_ch, 2'd0);
        chk("ar_rdy",  bus.in_meta_ready, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NC; i++) set_data(i, 16'h20 + 16'(i));
        bus.in_meta_valid  = 4'b1111;
        bus.out_meta_ready = 1'b1;
        #1 chk("ar_prio", bus.in_meta_ready, 4'b0001);
        @(negedge clk);
        chk("ar_first_ch",   bus.out_meta_ch, 2'd0);
        chk("ar_first_data", bus.out_meta_data, 16'h20);
        bus.in_meta_valid = 4'b0000;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
